// File: rtl/bit_error_counter_if.sv
// Handshake bundle for the noise-path bit error counter:
// window framing and samples in, latched results out.
interface bit_error_counter_if #(
   parameter int CNT_W = 10
);
   logic             enable;
   logic             sample_en;
   logic             xor_in;
   logic             clear;
   logic             busy;
   logic             done;
   logic             result_valid;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] bit_count;
   logic             pass;
   logic             overflow;

   modport master (
      output enable,
      output sample_en,
      output xor_in,
      output clear,
      input  busy,
      input  done,
      input  result_valid,
      input  err_count,
      input  bit_count,
      input  pass,
      input  overflow
   );

   modport slave (
      input  enable,
      input  sample_en,
      input  xor_in,
      input  clear,
      output busy,
      output done,
      output result_valid,
      output err_count,
      output bit_count,
      output pass,
      output overflow
   );
endinterface

// File: rtl/bit_error_counter.sv
// Counts sampled bit errors over one enable-framed test window
// and latches error/bit totals with a pass/fail verdict.
module bit_error_counter #(
   parameter int CNT_W       = 10,
   parameter int ERR_THRESH  = 0,
   parameter int SYNC_STAGES = 2
) (
   input logic                clk,
   input logic                rst_n,
   bit_error_counter_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] COUNT = 2'd1;
   localparam logic [1:0] LATCH = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [31:0]      THRESH  = $unsigned(ERR_THRESH);

   logic [1:0]             state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   err_s;

   logic [CNT_W-1:0] run_bits;
   logic [CNT_W-1:0] run_errs;
   logic             run_ovf;

   logic             busy_q;
   logic             done_q;
   logic             valid_q;
   logic [CNT_W-1:0] err_q;
   logic [CNT_W-1:0] bits_q;
   logic             pass_q;
   logic             ovf_q;

   logic             bit_sat;
   logic             err_sat;
   logic             pass_nx;

   // xor_in is asynchronous to clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.xor_in};
      end
   end

   assign err_s   = sync_q[SYNC_STAGES-1];
   assign bit_sat = (run_bits == CNT_MAX);
   assign err_sat = (run_errs == CNT_MAX);
   assign pass_nx = (32'(run_errs) <= THRESH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         run_bits <= '0;
         run_errs <= '0;
         run_ovf  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= '0;
         bits_q   <= '0;
         pass_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.clear) begin
                  err_q   <= '0;
                  bits_q  <= '0;
                  pass_q  <= 1'b0;
                  ovf_q   <= 1'b0;
                  valid_q <= 1'b0;
               end
               // entry edge: a coincident strobe is not counted
               if (bus.enable) begin
                  state    <= COUNT;
                  busy_q   <= 1'b1;
                  run_bits <= '0;
                  run_errs <= '0;
                  run_ovf  <= 1'b0;
                  valid_q  <= 1'b0;
                  pass_q   <= 1'b0;
               end
            end
            COUNT: begin
               if (!bus.enable) begin
                  state  <= LATCH;
                  busy_q <= 1'b0;
               end else if (bus.sample_en) begin
                  if (bit_sat) begin
                     run_ovf <= 1'b1;
                  end else begin
                     run_bits <= run_bits + 1'b1;
                  end
                  if (err_s) begin
                     if (err_sat) begin
                        run_ovf <= 1'b1;
                     end else begin
                        run_errs <= run_errs + 1'b1;
                     end
                  end
               end
            end
            LATCH: begin
               state   <= IDLE;
               err_q   <= run_errs;
               bits_q  <= run_bits;
               ovf_q   <= run_ovf;
               pass_q  <= pass_nx;
               valid_q <= 1'b1;
               done_q  <= 1'b1;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.result_valid = valid_q;
   assign bus.err_count    = err_q;
   assign bus.bit_count    = bits_q;
   assign bus.pass         = pass_q;
   assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_bit_error_counter.sv
// Randomized scoreboard bench for bit_error_counter: a wide and
// a 4-bit instance share stimulus; a monitor checks each done.
module tb_bit_error_counter;

   typedef struct {
      int     errs;
      int     bits;
      bit     ovf;
      bit     pass;
      longint done_cyc;
   } exp_t;

   localparam int THRESH = 0;

   logic   clk = 1'b0;
   logic   rst_n;
   logic   enable, sample_en, xor_in, clear;
   longint cyc = 0;
   int     checks = 0;
   int     errors = 0;

   exp_t sbq [2][$];
   bit   bits_q [$];

   bit_error_counter_if #(.CNT_W(10)) bb ();
   bit_error_counter_if #(.CNT_W(4))  sb ();

   assign bb.enable    = enable;
   assign bb.sample_en = sample_en;
   assign bb.xor_in    = xor_in;
   assign bb.clear     = clear;
   assign sb.enable    = enable;
   assign sb.sample_en = sample_en;
   assign sb.xor_in    = xor_in;
   assign sb.clear     = clear;

   bit_error_counter #(.CNT_W(10), .ERR_THRESH(THRESH), .SYNC_STAGES(2))
      dut_big (.clk(clk), .rst_n(rst_n), .bus(bb));

   bit_error_counter #(.CNT_W(4), .ERR_THRESH(THRESH), .SYNC_STAGES(2))
      dut_small (.clk(clk), .rst_n(rst_n), .bus(sb));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", nm, act, req);
      end
   endtask

   task automatic step(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   // Window result from counting rules alone: saturating totals.
   function automatic exp_t model(input int w, input longint fc);
      exp_t r;
      int n, e, mx;
      n  = bits_q.size();
      e  = 0;
      mx = (1 << w) - 1;
      foreach (bits_q[i]) e += int'(bits_q[i]);
      r.bits     = (n > mx) ? mx : n;
      r.errs     = (e > mx) ? mx : e;
      r.ovf      = (n > mx);
      r.pass     = (r.errs <= THRESH);
      r.done_cyc = fc + 2;
      return r;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_big_busy"},  bb.busy, 0);
      chk({tag, "_big_done"},  bb.done, 0);
      chk({tag, "_big_valid"}, bb.result_valid, 0);
      chk({tag, "_big_err"},   bb.err_count, 0);
      chk({tag, "_big_bits"},  bb.bit_count, 0);
      chk({tag, "_big_pass"},  bb.pass, 0);
      chk({tag, "_big_ovf"},   bb.overflow, 0);
      chk({tag, "_sm_valid"},  sb.result_valid, 0);
      chk({tag, "_sm_err"},    sb.err_count, 0);
      chk({tag, "_sm_bits"},   sb.bit_count, 0);
      chk({tag, "_sm_ovf"},    sb.overflow, 0);
   endtask

   task automatic mon_done(input int id, input int err, input int nb,
                           input logic ovf, input logic ps,
                           input logic rv, input logic bz);
      exp_t e;
      string t;
      t = (id == 0) ? "big" : "small";
      if (sbq[id].size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_unexpected_done actual 1 required 0", t);
      end else begin
         e = sbq[id].pop_front();
         chk({t, "_done_cycle"}, cyc, e.done_cyc);
         chk({t, "_err_count"}, err, e.errs);
         chk({t, "_bit_count"}, nb, e.bits);
         chk({t, "_overflow"}, ovf, e.ovf);
         chk({t, "_pass"}, ps, e.pass);
         chk({t, "_result_valid"}, rv, 1);
         chk({t, "_busy_at_done"}, bz, 0);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bb.done)
            mon_done(0, int'(bb.err_count), int'(bb.bit_count),
                     bb.overflow, bb.pass, bb.result_valid, bb.busy);
         if (sb.done)
            mon_done(1, int'(sb.err_count), int'(sb.bit_count),
                     sb.overflow, sb.pass, sb.result_valid, sb.busy);
      end
   end

   task automatic run_window(input bit entry_stb, input bit fall_stb,
                             input bit clr_cnt, input int gap,
                             input int abort_at);
      enable    = 1'b1;
      sample_en = entry_stb;
      xor_in    = 1'($urandom);
      step(1);
      sample_en = 1'b0;
      foreach (bits_q[i]) begin
         xor_in = bits_q[i];
         step(3);
         if (i == abort_at) begin
            #3;
            rst_n = 1'b0;
            #1;
            chk_zero("abort");
            enable    = 1'b0;
            sample_en = 1'b0;
            clear     = 1'b0;
            step(2);
            rst_n = 1'b1;
            step(2);
            return;
         end
         if (i == bits_q.size() / 2) begin
            chk("big_busy_mid", bb.busy, 1);
            chk("small_busy_mid", sb.busy, 1);
         end
         sample_en = 1'b1;
         clear     = clr_cnt & 1'($urandom);
         step(1);
         sample_en = 1'b0;
         clear     = 1'b0;
      end
      enable    = 1'b0;
      sample_en = fall_stb;
      xor_in    = 1'b1;
      sbq[0].push_back(model(10, cyc));
      sbq[1].push_back(model(4, cyc));
      step(1);
      sample_en = 1'b0;
      step(gap);
   endtask

   task automatic fill_random(input int n, input int pct);
      bits_q.delete();
      for (int i = 0; i < n; i++)
         bits_q.push_back($urandom_range(99, 0) < pct);
   endtask

   initial begin
      int pos, placed, nb, gp;
      rst_n     = 1'b0;
      enable    = 1'b0;
      sample_en = 1'b0;
      xor_in    = 1'b0;
      clear     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;
      step(2);

      fill_random(1000, 0);
      run_window(0, 0, 0, 2, -1);

      fill_random(1000, 0);
      placed = 0;
      while (placed < 7) begin
         pos = $urandom_range(999, 0);
         if (!bits_q[pos]) begin
            bits_q[pos] = 1'b1;
            placed++;
         end
      end
      run_window(1, 1, 0, 2, -1);

      fill_random(20, 100);
      run_window(0, 0, 0, 2, -1);

      fill_random(10, 50);
      run_window(1, 1, 0, 2, -1);

      fill_random(500, 30);
      run_window(0, 0, 0, 2, 250);

      fill_random(30, 40);
      run_window(1, 0, 0, 2, -1);

      fill_random(50, 20);
      run_window(0, 1, 1, 2, -1);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      @(negedge clk);
      chk_zero("clear_idle");
      step(1);

      for (int w = 0; w < 10; w++) begin
         nb = (w == 0) ? 0 : $urandom_range(40, 1);
         gp = (nb > 0) ? $urandom_range(3, 0) : $urandom_range(3, 1);
         fill_random(nb, $urandom_range(60, 0));
         run_window(1'($urandom), 1'($urandom), 1'($urandom), gp, -1);
      end

      step(6);
      chk("big_sb_empty", sbq[0].size(), 0);
      chk("small_sb_empty", sbq[1].size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
